dcache_mem_responder: RTL and testbench

- Responder end of the EXM-stage data-cache request/response bus; stands in for the dcache in unit and core-level simulation.
- Accepts packed requests from the memory-access unit and services them from an internal word-addressed SRAM with configurable latency.
- Returns the packed {ready, rvalid, rdata} response, and keeps read/write transaction counters for bench checks.

---
 rtl/dcache_mem_responder.sv | 135 +++++++++++++
 tb/tb_dcache_mem_responder.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_mem_responder.sv
// Data-cache stand-in: services packed EXM-stage requests from a word-addressed SRAM with
// configurable read latency, and counts accepted reads and writes.
module dcache_mem_responder #(
    parameter int unsigned DEPTH_LOG2 = 10,
    parameter int unsigned RD_LAT     = 2,
    parameter int unsigned UC_EXTRA   = 3
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [105:0] req_bus,
    output logic [33:0]  resp_bus,
    input  logic         stall,
    output logic [31:0]  rd_cnt,
    output logic [31:0]  wr_cnt
);
    localparam int unsigned Depth = 2 ** DEPTH_LOG2;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StResp
    } state_e;

    state_e                  state_q, state_d;
    logic [4:0]              cnt_q, cnt_d;
    logic [DEPTH_LOG2-1:0]   idx_q, idx_d;
    logic [31:0]             rd_cnt_q, rd_cnt_d;
    logic [31:0]             wr_cnt_q, wr_cnt_d;
    logic [31:0]             mem_q [Depth];

    logic                    req_valid;
    logic                    req_op;
    logic [31:0]             req_addr;
    logic                    req_unc;
    logic [3:0]              req_strb;
    logic [31:0]             req_wdata;
    logic                    req_cacop;
    logic [DEPTH_LOG2-1:0]   req_idx;
    logic [4:0]              lat_load;

    logic                    ready;
    logic                    rvalid;
    logic [31:0]             rdata;
    logic                    accept;
    logic                    mem_we;
    logic                    unused_bits;

    assign req_valid = req_bus[105];
    assign req_op    = req_bus[104];
    assign req_addr  = req_bus[103:72];
    assign req_unc   = req_bus[71];
    assign req_strb  = req_bus[70:67];
    assign req_wdata = req_bus[66:35];
    assign req_cacop = req_bus[34];
    assign req_idx   = req_addr[DEPTH_LOG2+1:2];

    // Cache-op code/address, byte offset and aliased upper address bits carry no meaning here.
    assign unused_bits = ^{req_addr[1:0], req_addr[31:DEPTH_LOG2+2], req_bus[33:0]};

    assign lat_load = 5'(RD_LAT - 1) + (req_unc ? 5'(UC_EXTRA) : 5'd0);
    assign accept   = req_valid & ready;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        rd_cnt_d = rd_cnt_q;
        wr_cnt_d = wr_cnt_q;
        ready    = 1'b0;
        rvalid   = 1'b0;
        rdata    = 32'b0;
        mem_we   = 1'b0;
        case (state_q)
            StIdle: begin
                ready = ~stall & ~reset;
                if (accept && !req_cacop) begin
                    if (req_op) begin
                        mem_we   = 1'b1;
                        wr_cnt_d = wr_cnt_q + 32'd1;
                    end else begin
                        idx_d    = req_idx;
                        cnt_d    = lat_load;
                        rd_cnt_d = rd_cnt_q + 32'd1;
                        state_d  = (lat_load == 5'd0) ? StResp : StWait;
                    end
                end
            end
            StWait: begin
                cnt_d = cnt_q - 5'd1;
                if (cnt_q == 5'd1) begin
                    state_d = StResp;
                end
            end
            StResp: begin
                // Read in this cycle so that any earlier write is reflected.
                rvalid  = ~reset;
                rdata   = reset ? 32'b0 : mem_q[idx_q];
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            cnt_q    <= 5'd0;
            idx_q    <= '0;
            rd_cnt_q <= 32'd0;
            wr_cnt_q <= 32'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            rd_cnt_q <= rd_cnt_d;
            wr_cnt_q <= wr_cnt_d;
        end
    end

    // SRAM contents survive reset; acceptance already requires reset low.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (req_strb[i]) begin
                    mem_q[req_idx][8*i +: 8] <= req_wdata[8*i +: 8];
                end
            end
        end
    end

    assign resp_bus = {ready, rvalid, rdata};
    assign rd_cnt   = rd_cnt_q;
    assign wr_cnt   = wr_cnt_q;

endmodule

// File: tb/tb_dcache_mem_responder.sv
// Bench for dcache_mem_responder: directed scenarios plus random traffic, every cycle compared
// against a timestamp-based reference of the responder.
module tb_dcache_mem_responder;
    localparam int unsigned DEPTH_LOG2 = 10;
    localparam int unsigned RD_LAT     = 2;
    localparam int unsigned UC_EXTRA   = 3;
    localparam int unsigned Depth      = 2 ** DEPTH_LOG2;

    logic         clk = 1'b0;
    logic [105:0] req_bus;
    logic [33:0]  resp_bus;
    logic [31:0]  rd_cnt;
    logic [31:0]  wr_cnt;

    logic        d_v = 1'b0, d_op = 1'b0, d_unc = 1'b0, d_cac = 1'b0;
    logic        d_stall = 1'b0, d_rst = 1'b1;
    logic [31:0] d_addr = '0, d_wdata = '0, d_caddr = '0;
    logic [3:0]  d_strb = '0;
    logic [1:0]  d_code = '0;

    int unsigned n_cmp = 0;
    int unsigned n_mis = 0;

    // Reference: memory image, pending read with its due cycle, transaction counts.
    logic [31:0] m_mem [Depth];
    bit          m_pend = 0;
    bit          m_live = 0;
    int unsigned m_resp_at = 0;
    int unsigned m_ridx = 0;
    logic [31:0] m_rdc = '0, m_wrc = '0;
    int unsigned cyc = 0;
    int unsigned acc_cyc = 0;
    int unsigned rv_cyc = 0;
    logic [31:0] last_rdata = '0;

    assign req_bus = {d_v, d_op, d_addr, d_unc, d_strb, d_wdata, d_cac, d_code, d_caddr};

    always #5 clk = ~clk;

    dcache_mem_responder #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .RD_LAT     (RD_LAT),
        .UC_EXTRA   (UC_EXTRA)
    ) dut (
        .clk      (clk),
        .reset    (d_rst),
        .req_bus  (req_bus),
        .resp_bus (resp_bus),
        .stall    (d_stall),
        .rd_cnt   (rd_cnt),
        .wr_cnt   (wr_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_mis++;
            $error("FAIL %s @cyc %0d: got %h, expected %h", tag, cyc, obs, exp);
        end
    endtask

    // One clock cycle: inputs are already driven; check at negedge, then advance the model.
    task automatic cycle();
        bit          exp_ready, exp_rv;
        logic [31:0] exp_rd;
        int unsigned idx;
        @(negedge clk);
        exp_ready = !d_rst && !m_pend && !d_stall;
        exp_rv    = !d_rst && m_pend && (cyc == m_resp_at);
        exp_rd    = exp_rv ? m_mem[m_ridx] : 32'b0;
        chk("ready", {31'b0, resp_bus[33]}, {31'b0, exp_ready});
        chk("rvalid", {31'b0, resp_bus[32]}, {31'b0, exp_rv});
        chk("rdata", resp_bus[31:0], exp_rd);
        if (!d_rst && m_live) begin
            chk("rd_cnt", rd_cnt, m_rdc);
            chk("wr_cnt", wr_cnt, m_wrc);
        end
        if (resp_bus[32] === 1'b1) begin
            last_rdata = resp_bus[31:0];
            rv_cyc     = cyc;
        end
        idx = (d_addr >> 2) % Depth;
        if (d_rst) begin
            m_pend = 0;
            m_rdc  = '0;
            m_wrc  = '0;
            m_live = 1;
        end else if (exp_ready && d_v) begin
            if (!d_cac && d_op) begin
                for (int i = 0; i < 4; i++)
                    if (d_strb[i]) m_mem[idx][8*i +: 8] = d_wdata[8*i +: 8];
                m_wrc = m_wrc + 1;
            end else if (!d_cac) begin
                m_rdc     = m_rdc + 1;
                m_pend    = 1;
                m_resp_at = cyc + RD_LAT + (d_unc ? UC_EXTRA : 0);
                m_ridx    = idx;
                acc_cyc   = cyc;
            end
        end else if (m_pend && cyc == m_resp_at) begin
            m_pend = 0;
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_req();
        d_v = 0; d_op = 0; d_unc = 0; d_cac = 0; d_strb = '0;
    endtask

    task automatic do_write(input logic [31:0] a, input logic [3:0] s, input logic [31:0] w);
        d_v = 1; d_op = 1; d_cac = 0; d_unc = 0; d_addr = a; d_strb = s; d_wdata = w;
        cycle();
        idle_req();
    endtask

    task automatic do_read(input logic [31:0] a, input logic u);
        d_v = 1; d_op = 0; d_cac = 0; d_unc = u; d_addr = a; d_strb = '0;
        cycle();
        idle_req();
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 40; i++) begin
            if (!m_pend) break;
            cycle();
        end
        cycle();
    endtask

    initial begin
        int unsigned rv_before;
        for (int i = 0; i < Depth; i++) m_mem[i] = '0;

        d_rst = 1;
        cycle();
        cycle();
        d_rst = 0;
        cycle();

        // Fill every word, with random aliasing bits and byte offset in the address.
        for (int i = 0; i < Depth; i++) begin
            logic [31:0] a;
            a = {$urandom_range(0, 1048575), 10'(i), 2'($urandom_range(0, 3))};
            do_write(a, 4'hF, $urandom);
        end

        d_rst = 1;
        cycle();
        d_rst = 0;

        // Write then read back.
        do_write(32'h1C, 4'hF, 32'hDEADBEEF);
        do_read(32'h1C, 0);
        wait_idle();
        chk("wr_rd_data", last_rdata, 32'hDEADBEEF);
        chk("wr_rd_lat", rv_cyc - acc_cyc, 32'd2);
        chk("wr_rd_rdcnt", rd_cnt, 32'd1);
        chk("wr_rd_wrcnt", wr_cnt, 32'd1);

        // Single byte lane.
        do_write(32'h1D, 4'b0010, 32'h0000AA00);
        do_read(32'h1C, 0);
        wait_idle();
        chk("strb_data", last_rdata, 32'hDEADAAEF);

        // Uncached latency.
        do_read(32'hBFA00010, 1);
        wait_idle();
        chk("uc_lat", rv_cyc - acc_cyc, 32'd5);
        chk("uc_data", last_rdata, m_mem[4]);

        // Backpressure holds off a valid read.
        d_v = 1; d_op = 0; d_addr = 32'h1C; d_stall = 1;
        repeat (3) cycle();
        chk("bp_rdcnt", rd_cnt, 32'd3);
        d_stall = 0;
        cycle();
        idle_req();
        wait_idle();
        chk("bp_lat", rv_cyc - acc_cyc, 32'd2);
        chk("bp_rdcnt2", rd_cnt, 32'd4);

        // Reset aborts an in-flight read.
        rv_before = rv_cyc;
        do_read(32'h20, 0);
        d_rst = 1;
        cycle();
        d_rst = 0;
        repeat (8) cycle();
        chk("rst_no_rvalid", rv_cyc, rv_before);
        chk("rst_rdcnt", rd_cnt, 32'd0);

        // Cache op leaves memory and counters alone; aliased read returns word 7.
        d_v = 1; d_op = 1; d_cac = 1; d_addr = 32'h1C; d_strb = 4'hF; d_wdata = 32'h12345678;
        d_code = 2'b11; d_caddr = 32'h1C;
        cycle();
        idle_req();
        chk("cacop_wrcnt", wr_cnt, 32'd0);
        do_read(32'h101C, 0);
        wait_idle();
        chk("alias_data", last_rdata, 32'hDEADAAEF);

        // Random traffic.
        for (int n = 0; n < 3000; n++) begin
            d_v     = ($urandom_range(0, 9) < 6);
            d_op    = $urandom_range(0, 1);
            d_unc   = ($urandom_range(0, 3) == 0);
            d_cac   = ($urandom_range(0, 9) == 0);
            d_stall = ($urandom_range(0, 3) == 0);
            d_rst   = ($urandom_range(0, 99) == 0);
            d_addr  = $urandom;
            d_strb  = 4'($urandom_range(0, 15));
            d_wdata = $urandom;
            d_code  = 2'($urandom_range(0, 3));
            d_caddr = $urandom;
            cycle();
        end
        d_rst = 0; d_stall = 0;
        idle_req();
        wait_idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
